// File: rtl/div_pkg.sv
// Shared definitions for the EX-stage integer divider: op indices, FSM states, default width.
// No logic, so no latency of its own.
// No handshakes at this level.
package div_pkg;

  localparam int W_DEFAULT = 32;

  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted remainder.
// Purely combinational.
// No handshake; the caller decides when to register the outputs.
module div_step
  import div_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] rem,
  input  logic         dividend_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W+1:0] trial;
  logic         unused_hi;

  // The remainder MSB is kept in the trial: for unsigned divisors above 2^(W-1)
  // the shifted remainder can exceed W bits, and a borrow bit is needed beyond that.
  assign shifted   = {rem, dividend_msb};
  assign trial     = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit     = ~trial[W+1];
  assign rem_next  = q_bit ? trial[W-1:0] : shifted[W-1:0];
  assign unused_hi = ^{trial[W], shifted[W]};

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU; DIV_EARLY_OUT_EN enables the 1-cycle early-out path.
// Latency W+1 cycles from acceptance to out_valid (1 cycle on early-out); no overlap, issue spacing W+2.
// in_ready only in IDLE; out_valid/div_result hold until out_ready; flush overrides all and returns to IDLE.
module div_unit
  import div_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [3:0]   div_op,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] div_src1,
  input  logic [W-1:0] div_src2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] div_result,
  input  logic         flush
);

  localparam int CW = $clog2(W);

  div_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] rem_q, quot_q, dsr_q, result_q;
  logic         is_div_q, q_neg_q, r_neg_q, dz_q;

  logic         accept, is_signed, is_div, s1, s2, dz, early;
  logic [W-1:0] mag1, mag2, early_res;
  logic [W-1:0] rem_nxt, quot_nxt, q_fix, r_fix, final_res;
  logic         q_bit;

  assign accept    = in_valid & in_ready & ~flush;
  assign is_signed = div_op[DIV_W] | div_op[MOD_W];
  assign is_div    = div_op[DIV_W] | div_op[DIV_WU];
  assign s1        = is_signed & div_src1[W-1];
  assign s2        = is_signed & div_src2[W-1];
  assign mag1      = s1 ? -div_src1 : div_src1;
  assign mag2      = s2 ? -div_src2 : div_src2;
  assign dz        = (div_src2 == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = dz | (mag1 < mag2);
`else
  assign early = 1'b0;
`endif
  // Early-out results need no sign fix-up: quotient is 0 (or all ones) and remainder is the raw dividend.
  assign early_res = is_div ? (dz ? '1 : '0) : div_src1;

  div_step #(.W(W)) u_step (
    .rem          (rem_q),
    .dividend_msb (quot_q[W-1]),
    .divisor      (dsr_q),
    .rem_next     (rem_nxt),
    .q_bit        (q_bit)
  );

  assign quot_nxt  = {quot_q[W-2:0], q_bit};
  // Divide-by-zero bypasses quotient negation; the remainder fix-up restores the original dividend.
  assign q_fix     = dz_q ? '1 : (q_neg_q ? -quot_nxt : quot_nxt);
  assign r_fix     = r_neg_q ? -rem_nxt : rem_nxt;
  assign final_res = is_div_q ? q_fix : r_fix;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)    state_nxt = early ? DONE : CALC;
        CALC:    if (cnt == '0)   state_nxt = DONE;
        DONE:    if (out_ready)   state_nxt = IDLE;
        default:                  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else if (accept) begin
      cnt      <= CW'(W - 1);
      rem_q    <= '0;
      quot_q   <= mag1;
      dsr_q    <= mag2;
      is_div_q <= is_div;
      q_neg_q  <= s1 ^ s2;
      r_neg_q  <= s1;
      dz_q     <= dz;
      if (early) result_q <= early_res;
    end else if (state == CALC && !flush) begin
      rem_q  <= rem_nxt;
      quot_q <= quot_nxt;
      if (cnt != '0) cnt <= cnt - 1'b1;
      else           result_q <= final_res;
    end
  end

  assign div_result = result_q;

endmodule
